// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - request/result bundle for the multi-cycle multiply/divide sequencer
//
// Signals:
//   start    request, sampled only while the sequencer is idle
//   op       op[0]: 0=multiply 1=divide; op[1]: signed (SIGNED_MD_EN builds only)
//   src_a    multiplicand / dividend
//   src_b    multiplier / divisor
//   busy     operation in progress
//   done     one-cycle result-valid pulse
//   hi, lo   product[63:32]/remainder, product[31:0]/quotient
//   div_zero last divide had src_b==0
// master = pipeline side, slave = sequencer side.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, src_a, src_b,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, src_a, src_b,
    output busy, done, hi, lo, div_zero
  );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle MULTU/DIVU (optionally MULT/DIV) sequencer driving the shared ALU
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   md       muldiv_seq_if.slave request/result bundle
//   alu_a    shared ALU operand a
//   alu_b    shared ALU operand b
//   alu_gin  shared ALU control (010 ADD, 110 SUB)
//   alu_sum  shared ALU result, combinational return
//
// Optional macro SIGNED_MD_EN: op[1] selects signed MULT/DIV. Operands are
// converted to magnitudes on acceptance and a one-cycle FIX state restores
// the result signs, giving 33-edge latency instead of 32.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  muldiv_seq_if.slave      md,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_gin,
  input  logic [WIDTH-1:0] alu_sum
);
  localparam logic [2:0] GIN_ADD = 3'b010;
  localparam logic [2:0] GIN_SUB = 3'b110;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef SIGNED_MD_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN} state_t;
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic [WIDTH-1:0] acc;      // P_hi for multiply, R for divide
  logic [WIDTH-1:0] lo_q;     // P_lo for multiply, Q for divide
  logic [WIDTH-1:0] opnd;     // M for multiply, D for divide
  logic [WIDTH-1:0] acc_nxt, lo_nxt;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             done_r, div_zero_r;
  logic             start_dz, last, carry, nob, ok;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign start_dz = md.op[0] && (md.src_b == '0);
  assign last     = (cnt == LAST_CNT);

`ifdef SIGNED_MD_EN
  localparam logic [WIDTH-1:0]   ONE  = 1;
  localparam logic [2*WIDTH-1:0] ONE2 = 1;
  logic sa, sb, sa_in, sb_in;
  logic [2*WIDTH-1:0] prod_mag;
  assign sa_in    = md.op[1] & md.src_a[WIDTH-1];
  assign sb_in    = md.op[1] & md.src_b[WIDTH-1];
  assign mag_a    = sa_in ? (~md.src_a + ONE) : md.src_a;
  assign mag_b    = sb_in ? (~md.src_b + ONE) : md.src_b;
  assign prod_mag = {acc, lo_q};
`else
  logic unused_op1;
  assign unused_op1 = md.op[1];
  assign mag_a      = md.src_a;
  assign mag_b      = md.src_b;
`endif

  // One shift-add / restoring-subtract step using the shared ALU result.
  always_comb begin
    carry = (alu_a[WIDTH-1] & alu_b[WIDTH-1]) |
            ((alu_a[WIDTH-1] | alu_b[WIDTH-1]) & ~alu_sum[WIDTH-1]);
    nob   = (alu_a[WIDTH-1] & ~alu_b[WIDTH-1]) |
            ((alu_a[WIDTH-1] | ~alu_b[WIDTH-1]) & ~alu_sum[WIDTH-1]);
    // A set R[31] means the shifted remainder already exceeds any divisor.
    ok    = acc[WIDTH-1] | nob;
    if (is_div) begin
      acc_nxt = ok ? alu_sum : alu_a;
      lo_nxt  = {lo_q[WIDTH-2:0], ok};
    end else if (lo_q[0]) begin
      {acc_nxt, lo_nxt} = {carry, alu_sum, lo_q[WIDTH-1:1]};
    end else begin
      {acc_nxt, lo_nxt} = {1'b0, acc, lo_q[WIDTH-1:1]};
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (md.start && !start_dz) state_nxt = S_RUN;
`ifdef SIGNED_MD_EN
      S_RUN:  if (last) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_IDLE;
`else
      S_RUN:  if (last) state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: ALU drive and busy
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_gin = GIN_ADD;
    md.busy = (state != S_IDLE);
    if (state == S_RUN) begin
      alu_b = opnd;
      if (is_div) begin
        alu_a   = {acc[WIDTH-2:0], lo_q[WIDTH-1]};
        alu_gin = GIN_SUB;
      end else begin
        alu_a = acc;
      end
    end
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      is_div     <= 1'b0;
      acc        <= '0;
      lo_q       <= '0;
      opnd       <= '0;
      hi_r       <= '0;
      lo_r       <= '0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
`ifdef SIGNED_MD_EN
      sa         <= 1'b0;
      sb         <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (md.start) begin
            if (start_dz) begin
              hi_r       <= md.src_a;
              lo_r       <= '1;
              div_zero_r <= 1'b1;
              done_r     <= 1'b1;
            end else begin
              div_zero_r <= 1'b0;
              cnt        <= '0;
              is_div     <= md.op[0];
              acc        <= '0;
              lo_q       <= md.op[0] ? mag_a : mag_b;
              opnd       <= md.op[0] ? mag_b : mag_a;
`ifdef SIGNED_MD_EN
              sa         <= sa_in;
              sb         <= sb_in;
`endif
            end
          end
        end
        S_RUN: begin
          acc  <= acc_nxt;
          lo_q <= lo_nxt;
          cnt  <= last ? '0 : cnt + 1'b1;
`ifndef SIGNED_MD_EN
          if (last) begin
            hi_r   <= acc_nxt;
            lo_r   <= lo_nxt;
            done_r <= 1'b1;
          end
`endif
        end
`ifdef SIGNED_MD_EN
        S_FIX: begin
          if (is_div) begin
            hi_r <= sa ? (~acc + ONE) : acc;
            lo_r <= (sa ^ sb) ? (~lo_q + ONE) : lo_q;
          end else begin
            {hi_r, lo_r} <= (sa ^ sb) ? (~prod_mag + ONE2) : prod_mag;
          end
          done_r <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign md.done     = done_r;
  assign md.hi       = hi_r;
  assign md.lo       = lo_r;
  assign md.div_zero = div_zero_r;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed self-checking bench for muldiv_seq
module tb_muldiv_seq;
`ifdef SIGNED_MD_EN
  localparam int LAT = 33;
`else
  localparam int LAT = 32;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_a, alu_b, alu_sum;
  logic [2:0]  alu_gin;

  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   lat;
  logic bseen, gbad, dseen;

  muldiv_seq_if mif ();

  muldiv_seq dut (
    .clk     (clk),
    .reset   (reset),
    .md      (mif),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_gin (alu_gin),
    .alu_sum (alu_sum)
  );

  always #5 clk = ~clk;

  // Shared ALU model: ADD on 010, SUB on 110.
  assign alu_sum = (alu_gin == 3'b110) ? (alu_a - alu_b) : (alu_a + alu_b);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait (bounded) for done. lat = edges after E0 until done seen.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] gexp);
    @(negedge clk);
    mif.start = 1'b1; mif.op = o; mif.src_a = a; mif.src_b = b;
    @(posedge clk);
    @(negedge clk);
    mif.start = 1'b0;
    lat = 0; bseen = 1'b0; gbad = 1'b0;
    while (mif.done !== 1'b1 && lat < 100) begin
      bseen = bseen | mif.busy;
      if (mif.busy === 1'b1 && dut.state == dut.S_RUN && alu_gin !== gexp) gbad = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    bseen = bseen | mif.busy;
  endtask

  initial begin
    reset = 1'b0;
    mif.start = 1'b0; mif.op = 2'b00; mif.src_a = '0; mif.src_b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", mif.busy, 1'b0);
    check("rst_done", mif.done, 1'b0);
    check("rst_hi", mif.hi, 32'h0);
    check("rst_lo", mif.lo, 32'h0);
    check("rst_dz", mif.div_zero, 1'b0);
    check("rst_gin", alu_gin, 3'b010);
    reset = 1'b1;

    // DIVU 100/7
    run_op(2'b01, 32'd100, 32'd7, 3'b110);
    check("divu100_lat", lat, LAT);
    check("divu100_hi", mif.hi, 32'd2);
    check("divu100_lo", mif.lo, 32'd14);
    check("divu100_dz", mif.div_zero, 1'b0);
    check("divu100_gin", gbad, 1'b0);

    // Reset mid-RUN of MULTU 7*9
    @(negedge clk);
    mif.start = 1'b1; mif.op = 2'b00; mif.src_a = 32'd7; mif.src_b = 32'd9;
    @(negedge clk);
    mif.start = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy_before", mif.busy, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", mif.busy, 1'b0);
    check("mid_rst_done", mif.done, 1'b0);
    check("mid_rst_hi", mif.hi, 32'h0);
    check("mid_rst_lo", mif.lo, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    dseen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      dseen = dseen | mif.done;
    end
    check("mid_no_done", dseen, 1'b0);

    // MULTU FFFFFFFF*FFFFFFFF
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b010);
    check("mulff_lat", lat, LAT);
    check("mulff_hi", mif.hi, 32'hFFFFFFFE);
    check("mulff_lo", mif.lo, 32'h00000001);
    check("mulff_gin", gbad, 1'b0);
    @(negedge clk);
    check("mulff_done_pulse", mif.done, 1'b0);
    check("mulff_hold_lo", mif.lo, 32'h00000001);

    // DIVU FFFFFFFF/1
    run_op(2'b01, 32'hFFFFFFFF, 32'd1, 3'b110);
    check("divff_hi", mif.hi, 32'h0);
    check("divff_lo", mif.lo, 32'hFFFFFFFF);

    // DIVU 5/0
    run_op(2'b01, 32'd5, 32'd0, 3'b110);
    check("dz_lat", lat, 0);
    check("dz_hi", mif.hi, 32'd5);
    check("dz_lo", mif.lo, 32'hFFFFFFFF);
    check("dz_flag", mif.div_zero, 1'b1);
    check("dz_busy", bseen, 1'b0);
    @(negedge clk);
    check("dz_done_drop", mif.done, 1'b0);
    check("dz_hold", mif.div_zero, 1'b1);

    // start held high through MULTU 7*9, operands disturbed mid-RUN,
    // then DIVU 100/7 accepted in the done cycle.
    mif.start = 1'b1; mif.op = 2'b00; mif.src_a = 32'd7; mif.src_b = 32'd9;
    @(posedge clk);
    @(negedge clk);
    check("b2b_dz_clear", mif.div_zero, 1'b0);
    check("b2b_busy1", mif.busy, 1'b1);
    mif.src_a = 32'd1000; mif.src_b = 32'd3; mif.op = 2'b01;
    lat = 0;
    while (mif.done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("b2b_mul_lat", lat, LAT);
    check("b2b_mul_hi", mif.hi, 32'd0);
    check("b2b_mul_lo", mif.lo, 32'd63);
    mif.op = 2'b01; mif.src_a = 32'd100; mif.src_b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    check("b2b_busy2", mif.busy, 1'b1);
    mif.start = 1'b0;
    lat = 0;
    while (mif.done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("b2b_div_lat", lat, LAT);
    check("b2b_div_hi", mif.hi, 32'd2);
    check("b2b_div_lo", mif.lo, 32'd14);

`ifdef SIGNED_MD_EN
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, 3'b110);
    check("sdiv_lat", lat, 33);
    check("sdiv_hi", mif.hi, 32'hFFFFFFFF);
    check("sdiv_lo", mif.lo, 32'hFFFFFFFD);
    run_op(2'b10, 32'hFFFFFFFD, 32'd5, 3'b010);
    check("smul_lat", lat, 33);
    check("smul_hi", mif.hi, 32'hFFFFFFFF);
    check("smul_lo", mif.lo, 32'hFFFFFFF1);
`else
    // op[1] ignored: (2^32-3)*5 unsigned
    run_op(2'b10, 32'hFFFFFFFD, 32'd5, 3'b010);
    check("uop1_lat", lat, 32);
    check("uop1_hi", mif.hi, 32'd4);
    check("uop1_lo", mif.lo, 32'hFFFFFFF1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle multiply/divide sequencer for the extended MIPS datapath; implements MULTU/DIVU (and optionally MULT/DIV) into HI/LO.
- Owns no adder; drives the shared 32-bit ALU each iteration using ALU control codes 010 (ADD) and 110 (SUB), and reads back the ALU sum.
- Sits beside the main ALU in EX; the pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand/ALU width. Must match the ALU; only 32 is supported.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when not busy
- op  in  2  op[0]: 0=multiply, 1=divide; op[1]: signed (only with SIGNED_MD_EN)
- src_a  in  32  multiplicand / dividend
- src_b  in  32  multiplier / divisor
- busy  out  1  operation in progress
- done  out  1  one-cycle result-valid pulse
- hi  out  32  product[63:32] / remainder
- lo  out  32  product[31:0] / quotient
- div_zero  out  1  last divide had src_b==0; held until next start
- alu_a  out  32  ALU operand a
- alu_b  out  32  ALU operand b
- alu_gin  out  3  ALU control line
- alu_sum  in  32  ALU result (combinational return)

Behaviour:
- Reset (async, reset=0): state IDLE; busy=0, done=0, hi=0, lo=0, div_zero=0, counter=0. Applies mid-operation; the partial result is discarded.
- States: IDLE, RUN (plus FIX with SIGNED_MD_EN).
- IDLE:
  - start=1 at edge E0 latches operands and op, clears div_zero, sets busy=1, and enters RUN with count=0.
  - Exception: divide with src_b==0 stays in IDLE and at E0 sets hi=src_a, lo=32'hFFFFFFFF, div_zero=1, done=1. No RUN cycles.
- RUN: one iteration per edge, E1..E32. At E32: hi/lo written, busy=0, done=1, state returns to IDLE.
- done is high for exactly one cycle; hi/lo hold until the next accepted start.
- A start while busy is ignored. A start in the same cycle as done=1 is accepted, so back-to-back ops have no gap.
- Multiply (unsigned shift-add):
  - Registers: P_hi (init 0), P_lo (init src_b), M (src_a).
  - ALU drive: alu_a=P_hi, alu_b=M, alu_gin=010.
  - carry = (a31&b31) | ((a31|b31)&~sum31).
  - If P_lo[0]=1: {P_hi,P_lo} <= {carry, alu_sum, P_lo[31:1]}. Otherwise: {P_hi,P_lo} <= {0, P_hi, P_lo[31:1]}.
  - Result: hi=P_hi, lo=P_lo.
- Divide (unsigned restoring):
  - Registers: R (init 0), Q (init src_a), D (src_b).
  - ALU drive: alu_a={R[30:0],Q[31]}, alu_b=D, alu_gin=110.
  - nob = (a31&~b31) | ((a31|~b31)&~sum31).
  - ok = R[31] | nob.
  - R <= ok ? alu_sum : alu_a; Q <= {Q[30:0], ok}.
  - Result: hi=R, lo=Q.
- ALU outputs are combinational from state registers. In IDLE: alu_a=0, alu_b=0, alu_gin=010.
- ALU overflow/zero/negative outputs are unused.

Optional Feature:
- Macro: SIGNED_MD_EN.
- Defined:
  - op[1]=1 selects signed MULT/DIV.
  - At E0, operands are converted to magnitudes using a local ~x+1 (not the ALU).
  - After RUN the block enters FIX for one cycle and negates the result as needed:
    - product sign = sa^sb
    - quotient sign = sa^sb
    - remainder sign = sa
  - Latency is 33 edges; done fires at E33. Divide-by-zero behaves as in the unsigned case.
- Not defined: op[1] ignored; every op is unsigned; FIX state absent.

Test Plan:
- Reset asserted mid-RUN of MULTU 7*9 -> busy=0, done=0, hi=lo=0 immediately; no done pulse follows.
- MULTU 32'hFFFFFFFF*32'hFFFFFFFF -> done at E32, hi=32'hFFFFFFFE, lo=32'h00000001. alu_gin=010 throughout RUN; carry path exercised.
- DIVU 100/7 -> hi=2, lo=14, div_zero=0. DIVU 32'hFFFFFFFF/1 -> lo=32'hFFFFFFFF, hi=0.
- DIVU 5/0 -> done one cycle after start, hi=5, lo=32'hFFFFFFFF, div_zero=1, busy never 1.
- start held high through an entire op -> second start accepted in the done cycle; busy high again next cycle; a start mid-RUN changes no result.
- (SIGNED_MD_EN) DIV -7/2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF at E33. MULT -3*5 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF1.
